// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // One complete display image; shadow and active copies share this shape.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_en;
  } disp_t;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment cathode pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with blanking, leading-zero
// suppression, blink and a frame-aligned load/pending handshake.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int N_SCAN  = 17,
  parameter int N_BLANK = 1024,
  parameter int N_BLINK = 26
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [31:0] Value,
  input  logic [7:0]  DigitEn,
  input  logic [7:0]  DpEn,
  input  logic        Blink,
  input  logic        LzSuppress,
  output logic [7:0]  An,
  output logic [6:0]  Cath,
  output logic        Dp,
  output logic        Pending,
  output logic        Frame
);

  localparam logic [N_SCAN-1:0] BLANK_END = N_SCAN'(N_BLANK);

  disp_t               shadow;
  disp_t               active;
  disp_t               in_data;
  logic [N_SCAN-1:0]   slot_cnt;
  logic [2:0]          idx;
  logic [N_BLINK-1:0]  blink_cnt;

  logic                tick;
  logic                frame_tick;
  logic [3:0]          cur_nibble;
  logic [6:0]          cur_seg;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                lit;

  assign in_data    = '{value: Value, digit_en: DigitEn, dp_en: DpEn};
  assign tick       = (slot_cnt == '1);
  assign frame_tick = tick && (idx == 3'd7);
  assign cur_nibble = active.value[{idx, 2'b00} +: 4];

  ssd_hex_decoder u_hex_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Digit k (k >= 1) is a leading zero when it and every enabled digit above it are zero.
  always_comb begin
    logic higher_nz;
    lz_mask   = '0;
    higher_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (!higher_nz && (active.value[4*k +: 4] == 4'h0)) lz_mask[k] = 1'b1;
      if (active.digit_en[k] && (active.value[4*k +: 4] != 4'h0)) higher_nz = 1'b1;
    end
  end

  assign lit = (slot_cnt >= BLANK_END)
            && active.digit_en[idx]
            && !(LzSuppress && lz_mask[idx])
            && !(Blink && blink_cnt[N_BLINK-1]);

  // Scan position, blink phase and the shadow/active handshake.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      shadow    <= '0;
      active    <= '0;
      slot_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      Pending   <= 1'b0;
      Frame     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register here see the pre-edge values of the others.
      slot_cnt  <= slot_cnt + N_SCAN'(1);
      blink_cnt <= blink_cnt + N_BLINK'(1);
      if (tick) idx <= idx + 3'd1;

      // Shadow also takes a coincident load so the next transfer cannot revert it.
      if (Load) shadow <= in_data;

      if (frame_tick) begin
        active  <= Load ? in_data : shadow;
        Pending <= 1'b0;
      end else if (Load) begin
        Pending <= 1'b1;
      end

      Frame <= frame_tick;
    end
  end

  // Registered pin drivers: one cycle behind the scan state above.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      An   <= 8'hFF;
      Cath <= SEG_BLANK;
      Dp   <= 1'b1;
    end else if (lit) begin
      An   <= ~(8'b0000_0001 << idx);
      Cath <= cur_seg;
      Dp   <= ~active.dp_en[idx];
    end else begin
      An   <= 8'hFF;
      Cath <= SEG_BLANK;
      Dp   <= 1'b1;
    end
  end

endmodule
